// File: rtl/wb_stream_loader_pkg.sv
// Shared FSM state encoding and Wishbone constant fields for the stream boot loader.
// No logic of its own.
package wb_stream_loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam logic [3:0] WB_SEL_ALL  = 4'hF;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_stream_loader_packer.sv
// Big-endian byte-to-word packer: word/word_vld are combinational on the 4th push.
// Never stalls; the caller decides when to push and clears it on state entry.
module wb_stream_loader_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  byte_dat,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_vld
);

  logic [1:0]  cnt;
  logic [23:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= 2'd0;
      shreg <= 24'd0;
    end else if (clear) begin
      cnt   <= 2'd0;
    end else if (push) begin
      cnt   <= cnt + 2'd1;
      shreg <= {shreg[15:0], byte_dat};
    end
  end

  // The 4th byte is merged in-flight so the caller can register the word on that same edge.
  assign word     = {shreg, byte_dat};
  assign word_vld = push && (cnt == 2'd3);

endmodule

// File: rtl/wb_stream_loader.sv
// Byte-stream boot loader: header word count, then packed words written over Wishbone; CPU held in reset until done.
// 4 byte cycles + 1..n bus cycles per word; s_ready_o low while a write waits for ack, and in DONE/ERROR.
module wb_stream_loader
  import wb_stream_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] MAX_WORDS = 32'd65536
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        error_o,
  output logic [31:0] words_o
);

  state_t      state;
  logic [31:0] word_count;
  logic        accept;
  logic        pk_clear;
  logic        pk_vld;
  logic [31:0] pk_word;

  assign accept   = s_valid_i & s_ready_o;
  assign pk_clear = (state != HDR) && (state != DATA);

  assign wbm_sel_o = WB_SEL_ALL;
  assign wbm_cti_o = CTI_CLASSIC;
  assign wbm_bte_o = BTE_LINEAR;

  wb_stream_loader_packer u_packer (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .push     (accept),
    .byte_dat (s_data_i),
    .clear    (pk_clear),
    .word     (pk_word),
    .word_vld (pk_vld)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= HDR;
      word_count <= 32'd0;
      s_ready_o  <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_adr_o  <= 32'd0;
      wbm_dat_o  <= 32'd0;
      cpu_rst_o  <= 1'b1;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
      words_o    <= 32'd0;
    end else begin
      case (state)
        HDR: begin
          s_ready_o <= 1'b1;
          if (pk_vld) begin
            word_count <= pk_word;
            if (pk_word == 32'd0) begin
              state     <= DONE;
              s_ready_o <= 1'b0;
              cpu_rst_o <= 1'b0;
              done_o    <= 1'b1;
            end else if (pk_word > MAX_WORDS) begin
              state     <= ERROR;
              s_ready_o <= 1'b0;
              error_o   <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (pk_vld) begin
            state     <= WRITE;
            s_ready_o <= 1'b0;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            wbm_adr_o <= BASE_ADDR + {words_o[29:0], 2'b00};
            wbm_dat_o <= pk_word;
          end
        end
        WRITE: begin
          // err wins over a simultaneous ack so a faulted write is never counted.
          if (wbm_err_i) begin
            state     <= ERROR;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            error_o   <= 1'b1;
          end else if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            words_o   <= words_o + 32'd1;
            if (words_o + 32'd1 == word_count) begin
              state     <= DONE;
              cpu_rst_o <= 1'b0;
              done_o    <= 1'b1;
            end else begin
              state     <= DATA;
              s_ready_o <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stream_loader.sv
// Randomized bench for wb_stream_loader: stream driver, Wishbone slave with random ack delay,
// and a word-level reference model of the expected writes and final status.
module tb_wb_stream_loader;

  localparam logic [31:0] BASE  = 32'hFFFF_FFF0;  // close to the top so writes wrap
  localparam logic [31:0] MAXW  = 32'd65536;
  localparam int          LIMIT = 3000;
  localparam int          NONE  = 1000;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [7:0]  s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, words_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i, wbm_err_i;
  logic        cpu_rst_o, done_o, error_o;

  wb_stream_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .s_data_i (s_data_i), .s_valid_i (s_valid_i), .s_ready_o (s_ready_o),
    .wbm_adr_o (wbm_adr_o), .wbm_dat_o (wbm_dat_o), .wbm_sel_o (wbm_sel_o),
    .wbm_we_o (wbm_we_o), .wbm_cyc_o (wbm_cyc_o), .wbm_stb_o (wbm_stb_o),
    .wbm_cti_o (wbm_cti_o), .wbm_bte_o (wbm_bte_o),
    .wbm_ack_i (wbm_ack_i), .wbm_err_i (wbm_err_i),
    .cpu_rst_o (cpu_rst_o), .done_o (done_o), .error_o (error_o), .words_o (words_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  pl_q[$];
  logic [31:0] wr_adr_q[$];
  logic [31:0] wr_dat_q[$];

  bit          rand_valid = 0, no_ack = 0, acc = 0, in_wait = 0;
  int          max_dly = 0, err_idx = NONE, w_idx = 0, dly = 0;
  int          n_acc = 0, acc_cyc = 0, ack_cyc = 0;
  logic [31:0] h_adr, h_dat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge wb_clk_i) cyc_cnt++;

  // Stream source: a byte offered at a negedge is consumed at the following posedge if ready.
  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      acc       = 0;
      s_valid_i = 1'b0;
    end else begin
      if (acc) begin
        void'(tx_q.pop_front());
        n_acc++;
      end
      if (tx_q.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
        s_valid_i = 1'b1;
        s_data_i  = tx_q[0];
      end else begin
        s_valid_i = 1'b0;
      end
      acc = s_valid_i && s_ready_o;
      if (acc) acc_cyc = cyc_cnt;
    end
  end

  // Wishbone slave: random wait states, records acked writes, checks the request holds still.
  always @(negedge wb_clk_i) begin
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    if (wb_rst_i || !(wbm_cyc_o && wbm_stb_o)) begin
      in_wait = 0;
    end else begin
      if (!in_wait) begin
        in_wait = 1;
        h_adr   = wbm_adr_o;
        h_dat   = wbm_dat_o;
        dly     = $urandom_range(0, max_dly);
        chk("we", 32'(wbm_we_o), 32'd1);
        chk("sel", 32'(wbm_sel_o), 32'hF);
        chk("cti_bte", 32'({wbm_cti_o, wbm_bte_o}), 32'd0);
        chk("ready_in_write", 32'(s_ready_o), 32'd0);
      end else begin
        chk("adr_stable", wbm_adr_o, h_adr);
        chk("dat_stable", wbm_dat_o, h_dat);
        chk("we_stable", 32'(wbm_we_o), 32'd1);
      end
      if (!no_ack) begin
        if (dly == 0) begin
          if (w_idx == err_idx) begin
            wbm_err_i = 1'b1;
          end else begin
            wbm_ack_i = 1'b1;
            wr_adr_q.push_back(wbm_adr_o);
            wr_dat_q.push_back(wbm_dat_o);
            ack_cyc = cyc_cnt;
          end
          w_idx++;
          in_wait = 0;
        end else begin
          dly--;
        end
      end
    end
  end

  task automatic apply_reset();
    wb_rst_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    tx_q.delete();
    wr_adr_q.delete();
    wr_dat_q.delete();
    n_acc  = 0;
    w_idx  = 0;
    no_ack = 0;
    chk("rst_ready", 32'(s_ready_o), 32'd0);
    chk("rst_ctl", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_dat", wbm_dat_o, 32'd0);
    chk("rst_status", 32'({cpu_rst_o, done_o, error_o}), 32'b100);
    chk("rst_words", words_o, 32'd0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("ready_after_rst", 32'(s_ready_o), 32'd1);
  endtask

  task automatic fill_random(input int nw);
    pl_q.delete();
    for (int k = 0; k < nw * 4; k++) pl_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Sends header n plus pl_q, waits for a terminal state, then compares with the model.
  task automatic run_load(input logic [31:0] n, input bit rv, input int md, input int eidx);
    int  t, exp_w, exp_bytes, fall_cyc, lim;
    bit  exp_err, fall_seen;
    logic [31:0] exp_dat;
    rand_valid = rv;
    max_dly    = md;
    err_idx    = eidx;
    tx_q.push_back(n[31:24]);
    tx_q.push_back(n[23:16]);
    tx_q.push_back(n[15:8]);
    tx_q.push_back(n[7:0]);
    foreach (pl_q[k]) tx_q.push_back(pl_q[k]);
    t = 0;
    fall_seen = 0;
    fall_cyc  = 0;
    while (!(done_o || error_o) && t < LIMIT) begin
      @(negedge wb_clk_i);
      t++;
      if (!fall_seen && !cpu_rst_o) begin
        fall_seen = 1;
        fall_cyc  = cyc_cnt;
      end
    end
    chk("finished", 32'(done_o | error_o), 32'd1);
    repeat (3) @(negedge wb_clk_i);

    if (n > MAXW) begin
      exp_err = 1; exp_w = 0; exp_bytes = 4;
    end else if (eidx < int'(n)) begin
      exp_err = 1; exp_w = eidx; exp_bytes = 4 + 4 * (eidx + 1);
    end else begin
      exp_err = 0; exp_w = int'(n); exp_bytes = 4 + 4 * exp_w;
    end

    chk("done", 32'(done_o), 32'(!exp_err));
    chk("error", 32'(error_o), 32'(exp_err));
    chk("cpu_rst", 32'(cpu_rst_o), 32'(exp_err));
    chk("ready_final", 32'(s_ready_o), 32'd0);
    chk("cyc_final", 32'(wbm_cyc_o), 32'd0);
    chk("words", words_o, 32'(exp_w));
    chk("bytes_taken", 32'(n_acc), 32'(exp_bytes));
    chk("n_writes", 32'(wr_adr_q.size()), 32'(exp_w));
    lim = (wr_adr_q.size() < exp_w) ? wr_adr_q.size() : exp_w;
    for (int i = 0; i < lim; i++) begin
      exp_dat = {pl_q[4*i], pl_q[4*i+1], pl_q[4*i+2], pl_q[4*i+3]};
      chk("wr_adr", wr_adr_q[i], BASE + 32'(4 * i));
      chk("wr_dat", wr_dat_q[i], exp_dat);
    end
    if (!exp_err)
      chk("rst_fall_cyc", 32'(fall_cyc), 32'(((n == 0) ? acc_cyc : ack_cyc) + 1));
    else
      chk("rst_held", 32'(fall_seen), 32'd0);
  endtask

  initial begin
    int t;
    wb_rst_i  = 1'b1;
    s_valid_i = 1'b0;
    s_data_i  = 8'd0;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;

    apply_reset();
    pl_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    run_load(32'd2, 0, 0, NONE);

    apply_reset();
    pl_q.delete();
    run_load(32'd0, 0, 0, NONE);

    apply_reset();
    pl_q.delete();
    run_load(MAXW + 32'd1, 0, 0, NONE);

    for (int it = 0; it < 6; it++) begin
      int nw;
      apply_reset();
      nw = $urandom_range(1, 6);
      fill_random(nw);
      run_load(32'(nw), 1, 7, NONE);
    end

    apply_reset();
    fill_random(5);
    run_load(32'd5, 1, 3, 2);

    // Reset while the first write is stalled on the bus, then a fresh load.
    apply_reset();
    no_ack = 1;
    fill_random(1);
    tx_q.push_back(8'h00); tx_q.push_back(8'h00); tx_q.push_back(8'h00); tx_q.push_back(8'h01);
    foreach (pl_q[k]) tx_q.push_back(pl_q[k]);
    t = 0;
    while (!wbm_stb_o && t < 200) begin
      @(negedge wb_clk_i);
      t++;
    end
    chk("stall_stb", 32'(wbm_stb_o), 32'd1);
    repeat (3) @(negedge wb_clk_i);
    chk("stall_hold", 32'(wbm_stb_o), 32'd1);
    @(posedge wb_clk_i);
    #2 wb_rst_i = 1'b1;
    #1 chk("async_drop", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
    apply_reset();
    fill_random(2);
    run_load(32'd2, 1, 2, NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
